i2c_temp_sensor_slave: RTL

I2C_TEMP_SENSOR_SLAVE -- requirements
Module: i2c_temp_sensor_slave

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_temp_sensor_slave_if.sv | 9 +
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_temp_sensor_slave.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C temperature-sensor slave.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK
   } i2c_state_t;

   localparam logic [6:0] DEF_SLAVE_ADDR = 7'h48;
   localparam logic       ACK            = 1'b0;
   localparam logic       NACK           = 1'b1;

endpackage

// File: rtl/i2c_temp_sensor_slave_if.sv
// Open-drain I2C bus seen by the slave: clock and resolved data in, pull-down enable out.
interface i2c_temp_sensor_slave_if;
   logic scl;
   logic sda_in;
   logic sda_oe;

   modport slave  (input  scl, input  sda_in, output sda_oe);
   modport master (output scl, output sda_in, input  sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_d, r_sda_d;
   logic                   w_scl, w_sda;

   assign w_scl = r_scl_sync[SYNC_STAGES-1];
   assign w_sda = r_sda_sync[SYNC_STAGES-1];

   // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
      end
   end

   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   assign o_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
   assign o_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// I2C register slave: pointer-addressed register file, reg 0 snapshots temp_in on each read.
module i2c_temp_sensor_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
   parameter int         NUM_REGS    = 4,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   i2c_temp_sensor_slave_if.slave      bus,
   input  logic [7:0]                  temp_in,
   output logic                        busy,
   output logic                        wr_valid,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [7:0]                  wr_data
);

   localparam int AW = $clog2(NUM_REGS);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   i2c_state_t                r_state;
   logic [3:0]                r_cnt;
   logic [7:0]                r_shift;
   logic                      r_rw, r_mack, r_sda_oe, r_busy, r_wr_valid;
   logic [AW-1:0]             r_ptr, r_wr_addr;
   logic [7:0]                r_wr_data;
   logic [NUM_REGS-1:0][7:0]  r_regs;
   logic                      w_sda, w_rise, w_fall, w_start, w_stop;
   logic [AW-1:0]             w_ptr_inc;
   logic [7:0]                w_first, w_next;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_scl     (bus.scl),
      .i_sda     (bus.sda_in),
      .o_sda     (w_sda),
      .o_scl_rise(w_rise),
      .o_scl_fall(w_fall),
      .o_start   (w_start),
      .o_stop    (w_stop)
   );

   // Reg 0 is loaded with temp_in on the same edge the first byte goes out, so bypass it.
   assign w_ptr_inc = r_ptr + PTR_ONE;
   assign w_first   = (r_ptr == '0) ? temp_in : r_regs[r_ptr];
   assign w_next    = r_regs[w_ptr_inc];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_rw       <= 1'b0;
         r_mack     <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_ptr      <= '0;
         r_regs     <= '0;
      end else begin
         r_wr_valid <= 1'b0;
         if (w_stop) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
         end else if (w_start) begin
            r_state  <= ST_ADDR;
            r_cnt    <= '0;
            r_sda_oe <= 1'b0;
         end else begin
            unique case (r_state)
               ST_IDLE: ;
               ST_ADDR, ST_PTR, ST_WR_DATA: begin
                  if (w_rise && r_cnt < 4'd8) begin
                     r_shift <= {r_shift[6:0], w_sda};
                     r_cnt   <= r_cnt + 4'd1;
                  end else if (w_fall && r_cnt == 4'd8) begin
                     r_cnt <= '0;
                     if (r_state == ST_ADDR) begin
                        if (r_shift[7:1] == SLAVE_ADDR) begin
                           r_state  <= ST_ADDR_ACK;
                           r_sda_oe <= 1'b1;
                           r_busy   <= 1'b1;
                           r_rw     <= r_shift[0];
                        end else begin
                           r_state <= ST_IDLE;
                        end
                     end else if (r_state == ST_PTR) begin
                        r_state  <= ST_PTR_ACK;
                        r_sda_oe <= 1'b1;
                        r_ptr    <= r_shift[AW-1:0];
                     end else begin
                        // Index 0 is read-only; its writes are ACKed but not committed.
                        r_state  <= ST_WR_ACK;
                        r_sda_oe <= 1'b1;
                        r_ptr    <= w_ptr_inc;
                        if (r_ptr != '0) begin
                           r_regs[r_ptr] <= r_shift;
                           r_wr_valid    <= 1'b1;
                           r_wr_addr     <= r_ptr;
                           r_wr_data     <= r_shift;
                        end
                     end
                  end
               end
               ST_ADDR_ACK: if (w_fall) begin
                  r_cnt <= '0;
                  if (r_rw) begin
                     r_regs[0] <= temp_in;
                     r_shift   <= w_first;
                     r_sda_oe  <= ~w_first[7];
                     r_state   <= ST_RD_DATA;
                  end else begin
                     r_sda_oe <= 1'b0;
                     r_state  <= ST_PTR;
                  end
               end
               ST_PTR_ACK, ST_WR_ACK: if (w_fall) begin
                  r_sda_oe <= 1'b0;
                  r_state  <= ST_WR_DATA;
               end
               ST_RD_DATA: begin
                  if (w_rise && r_cnt < 4'd8) begin
                     r_cnt <= r_cnt + 4'd1;
                  end else if (w_fall) begin
                     if (r_cnt == 4'd8) begin
                        r_cnt    <= '0;
                        r_sda_oe <= 1'b0;
                        r_state  <= ST_RD_ACK;
                     end else begin
                        r_sda_oe <= ~r_shift[6];
                        r_shift  <= {r_shift[6:0], 1'b0};
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (w_rise) begin
                     r_mack <= (w_sda == ACK);
                  end else if (w_fall) begin
                     if (r_mack) begin
                        r_ptr    <= w_ptr_inc;
                        r_shift  <= w_next;
                        r_sda_oe <= ~w_next[7];
                        r_cnt    <= '0;
                        r_state  <= ST_RD_DATA;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.sda_oe = r_sda_oe;
   assign busy       = r_busy;
   assign wr_valid   = r_wr_valid;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;

endmodule
